prt_dprx_vid_fifo_rdctl: RTL and testbench
==========================================

PRT_DPRX_VID_FIFO_RDCTL -- requirements
Module: prt_dprx_vid_fifo_rdctl

Interface
REQ-001 Parameters SHALL be: P_LANES, default 4, number of lanes; P_SEGMENTS, default 4, segments per lane; P_STRIPES, default 4 (legal 1..4), stripes per segment; P_LVL_W, default 6, width of the FIFO level.
REQ-002 Ports SHALL be as listed below (name, direction, width, meaning):
- VID_CLK_IN, in, 1: video clock. This is the only clock.
- VID_RST_N_IN, in, 1: reset, asynchronous, active-low.
- CTL_EN_IN, in, 1: controller enable.
- CFG_BLK_IN, in, 16: blocks per line; 0 is illegal.
- CFG_THR_IN, in, P_LVL_W: prefill threshold in blocks.
- VID_SOL_IN, in, 1: start-of-line pulse.
- VID_REQ_IN, in, 1: downstream ready.
- FIFO_LVL_IN, in, P_LVL_W: FIFO level in blocks.
- FIFO_RD_OUT, out, [P_STRIPES-1:0] per [P_LANES][P_SEGMENTS]: FIFO read strobes.
- FIFO_CLR_OUT, out, 1: FIFO clear pulse.
- VID_EOL_OUT, out, 1: end-of-line pulse.
- STA_BUSY_OUT, out, 1: line in progress.
- STA_UNF_OUT, out, 1: sticky underflow flag.
- STA_UNF_CLR_IN, in, 1: clears the underflow flag.

Function
REQ-003 All outputs SHALL be registered.
REQ-004 A block SHALL be one read of every FIFO. Stripe s of a block SHALL be read in a stripe cycle: FIFO_RD_OUT[i][j][s]=1 for all i,j, and every other bit 0.
REQ-005 A block SHALL take P_STRIPES stripe cycles, issued in order s=0..P_STRIPES-1.
REQ-006 A stripe cycle SHALL issue only when VID_REQ_IN=1. While VID_REQ_IN=0 the stripe index SHALL hold and no read SHALL issue.
REQ-007 The state machine SHALL have the states IDLE, PREFILL, RUN and DONE.
REQ-008 IDLE: when VID_SOL_IN=1 and CTL_EN_IN=1, the block SHALL load blk_cnt=CFG_BLK_IN, clear pend, and go to PREFILL.
REQ-009 PREFILL: when FIFO_LVL_IN >= CFG_THR_IN, the block SHALL go to RUN. If CFG_THR_IN=0, it SHALL go to RUN on the next cycle.
REQ-010 RUN, block start: stripe 0 of a new block SHALL issue only if FIFO_LVL_IN > pend and VID_REQ_IN=1.
- pend (0..2) counts block starts issued in the previous 2 cycles, which are not yet reflected in the level.
- pend SHALL be computed as a decision-time sliding count.
REQ-011 RUN, back-to-back: stripe 0 SHALL be allowed in the cycle directly after stripe P_STRIPES-1, which gives full throughput when the level is sufficient.
REQ-012 RUN, underflow: if VID_REQ_IN=1 at a block boundary but FIFO_LVL_IN <= pend, the block SHALL stall (no read) and set STA_UNF_OUT=1.
REQ-013 blk_cnt SHALL decrement on stripe 0 issue of each block. When the last stripe of the block with blk_cnt=0 has issued, the block SHALL go to DONE.
REQ-014 DONE SHALL last one cycle and assert VID_EOL_OUT=1 and FIFO_CLR_OUT=1, then return to IDLE.
REQ-015 STA_BUSY_OUT SHALL be 1 in PREFILL, RUN and DONE, and 0 in IDLE.
REQ-016 CTL_EN_IN=0 in any non-IDLE state SHALL abort the line:
- the next cycle SHALL have FIFO_RD_OUT all 0 and FIFO_CLR_OUT=1;
- VID_EOL_OUT SHALL NOT assert;
- the state SHALL go to IDLE.
- Partial blocks are discarded.
REQ-017 VID_SOL_IN outside IDLE SHALL be ignored, including in DONE.
REQ-018 CFG_BLK_IN and CFG_THR_IN SHALL be sampled only at the IDLE->PREFILL transition.
REQ-019 STA_UNF_CLR_IN SHALL clear STA_UNF_OUT. If a set and a clear occur in the same cycle, set SHALL win.
REQ-020 Arithmetic:
- the blk_cnt decrement SHALL be 16-bit with no wrap below 0;
- the level comparisons SHALL be unsigned at P_LVL_W bits, with pend zero-extended.

Reset
REQ-021 On VID_RST_N_IN=0 the block SHALL asynchronously set: state=IDLE, stripe index=0, blk_cnt=0, pend=0.
REQ-022 On VID_RST_N_IN=0 all outputs SHALL be 0: FIFO_RD_OUT, FIFO_CLR_OUT, VID_EOL_OUT, STA_BUSY_OUT, STA_UNF_OUT.
REQ-023 Reset release SHALL take effect on the first VID_CLK_IN rising edge after deassertion. No read SHALL issue before a VID_SOL_IN in IDLE.
REQ-024 Reset asserted mid-line SHALL abort the line immediately with no FIFO_CLR_OUT pulse.

Verification
REQ-025 The bench SHALL cover the following directed scenarios:
- Nominal: P_STRIPES=4, CFG_BLK_IN=3, CFG_THR_IN=2, FIFO_LVL_IN held at 8, VID_REQ_IN=1, one SOL -> 12 consecutive stripe cycles in pattern 0,1,2,3 x3, then 1 cycle of VID_EOL_OUT=FIFO_CLR_OUT=1, STA_UNF_OUT=0.
- Prefill: CFG_THR_IN=4, level ramps 0->4 one step per 10 cycles -> no read until the level reaches 4; first stripe 0 within 2 cycles after.
- Underflow/pend: P_STRIPES=1, level model = writes minus block starts, 1 block preloaded, no further writes -> exactly 1 read, then stall with STA_UNF_OUT=1; never 2 reads on 1 block.
- Backpressure: VID_REQ_IN toggled 1,0,0,1 during a block -> stripe sequence pauses and resumes at the next stripe; no stripe skipped or repeated.
- Abort: CTL_EN_IN=0 at block 2 stripe 1 -> next cycle FIFO_CLR_OUT=1, no VID_EOL_OUT, STA_BUSY_OUT=0 one cycle later; SOL during DONE ignored.
- Reset: VID_RST_N_IN=0 mid-RUN -> all outputs 0 asynchronously; after release no reads until a new SOL.

Source files
------------

// File: rtl/prt_dprx_vid_fifo_rdctl_if.sv
// rtl/prt_dprx_vid_fifo_rdctl_if.sv - video FIFO read-side handshake bundle
//
// Groups the signals between the read controller, the per-lane/segment/stripe
// FIFO array and the downstream video consumer.
//   VID_SOL_IN   : start-of-line pulse from the video timing side
//   VID_REQ_IN   : downstream ready; one stripe cycle may issue per cycle it is high
//   FIFO_LVL_IN  : FIFO fill level in blocks
//   FIFO_RD_OUT  : read strobes, [lane][segment][stripe]
//   FIFO_CLR_OUT : FIFO clear pulse (end of line or abort)
//   VID_EOL_OUT  : end-of-line pulse
// master = read controller, slave = FIFO/video side.
interface prt_dprx_vid_fifo_rdctl_if #(
    parameter int P_LANES    = 4,
    parameter int P_SEGMENTS = 4,
    parameter int P_STRIPES  = 4,
    parameter int P_LVL_W    = 6
);
    logic                                                  VID_SOL_IN;
    logic                                                  VID_REQ_IN;
    logic [P_LVL_W-1:0]                                    FIFO_LVL_IN;
    logic [P_LANES-1:0][P_SEGMENTS-1:0][P_STRIPES-1:0]    FIFO_RD_OUT;
    logic                                                  FIFO_CLR_OUT;
    logic                                                  VID_EOL_OUT;

    modport master (
        input  VID_SOL_IN,
        input  VID_REQ_IN,
        input  FIFO_LVL_IN,
        output FIFO_RD_OUT,
        output FIFO_CLR_OUT,
        output VID_EOL_OUT
    );

    modport slave (
        output VID_SOL_IN,
        output VID_REQ_IN,
        output FIFO_LVL_IN,
        input  FIFO_RD_OUT,
        input  FIFO_CLR_OUT,
        input  VID_EOL_OUT
    );
endinterface

// File: rtl/prt_dprx_vid_fifo_rdctl.sv
// rtl/prt_dprx_vid_fifo_rdctl.sv - DP RX video FIFO read controller
//
// Reads one video line out of a lane x segment x stripe FIFO array. A block is
// one read of every FIFO, issued as P_STRIPES stripe cycles (stripe 0 first).
// A line is CFG_BLK_IN blocks; before the first block the controller waits
// until the FIFO holds CFG_THR_IN blocks.
//
// Ports:
//   VID_CLK_IN     : video clock (only clock)
//   VID_RST_N_IN   : asynchronous active-low reset
//   CTL_EN_IN      : enable; low outside IDLE aborts the line
//   CFG_BLK_IN     : blocks per line, sampled at line start
//   CFG_THR_IN     : prefill threshold in blocks, sampled at line start
//   STA_BUSY_OUT   : line in progress
//   STA_UNF_OUT    : sticky underflow flag
//   STA_UNF_CLR_IN : clears STA_UNF_OUT (a simultaneous set wins)
//   vid_if         : FIFO/video handshake bundle (master side)
//
// Every output is a flop. The decision made in a cycle (read strobe, clear,
// end-of-line, busy) is therefore visible on the outputs one cycle later.
module prt_dprx_vid_fifo_rdctl #(
    parameter int P_LANES    = 4,
    parameter int P_SEGMENTS = 4,
    parameter int P_STRIPES  = 4,
    parameter int P_LVL_W    = 6
) (
    input  logic                          VID_CLK_IN,
    input  logic                          VID_RST_N_IN,
    input  logic                          CTL_EN_IN,
    input  logic [15:0]                   CFG_BLK_IN,
    input  logic [P_LVL_W-1:0]            CFG_THR_IN,
    output logic                          STA_BUSY_OUT,
    output logic                          STA_UNF_OUT,
    input  logic                          STA_UNF_CLR_IN,
    prt_dprx_vid_fifo_rdctl_if.master     vid_if
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PREFILL = 2'd1,
        ST_RUN     = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    typedef logic [P_LANES-1:0][P_SEGMENTS-1:0][P_STRIPES-1:0] rd_vec_t;

    localparam logic [1:0] LAST_STRIPE = 2'(P_STRIPES - 1);

    // State and line bookkeeping
    state_t                state_q,     state_d;
    logic [1:0]            stripe_q,    stripe_d;
    logic [15:0]           blk_cnt_q,   blk_cnt_d;
    logic [P_LVL_W-1:0]    thr_q,       thr_d;
    // Bit 0: block started by the previous decision, bit 1: the one before.
    // Those starts are not yet visible in FIFO_LVL_IN.
    logic [1:0]            pend_hist_q, pend_hist_d;

    // Registered outputs
    rd_vec_t               rd_q,        rd_d;
    logic                  clr_q,       clr_d;
    logic                  eol_q,       eol_d;
    logic                  busy_q,      busy_d;
    logic                  unf_q,       unf_d;

    // Decision-cycle helpers
    logic [1:0]            pend;
    logic [P_LVL_W-1:0]    pend_ext;
    logic                  abort;
    logic                  issue;
    logic                  issue_start;
    logic                  unf_set;
    logic [P_STRIPES-1:0]  stripe_oh;

    assign pend     = {1'b0, pend_hist_q[0]} + {1'b0, pend_hist_q[1]};
    assign pend_ext = P_LVL_W'(pend);
    assign abort    = (state_q != ST_IDLE) && !CTL_EN_IN;

    always_comb begin
        state_d     = state_q;
        stripe_d    = stripe_q;
        blk_cnt_d   = blk_cnt_q;
        thr_d       = thr_q;
        pend_hist_d = pend_hist_q;
        clr_d       = 1'b0;
        eol_d       = 1'b0;
        busy_d      = (state_q != ST_IDLE);
        issue       = 1'b0;
        issue_start = 1'b0;
        unf_set     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (vid_if.VID_SOL_IN && CTL_EN_IN) begin
                    blk_cnt_d = CFG_BLK_IN;
                    thr_d     = CFG_THR_IN;
                    stripe_d  = 2'd0;
                    state_d   = ST_PREFILL;
                end
            end

            ST_PREFILL: begin
                if (vid_if.FIFO_LVL_IN >= thr_q) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (vid_if.VID_REQ_IN) begin
                    if (stripe_q == 2'd0) begin
                        // A new block needs a whole block in the FIFO beyond
                        // the starts the level has not caught up with yet.
                        if (vid_if.FIFO_LVL_IN > pend_ext) begin
                            issue       = 1'b1;
                            issue_start = 1'b1;
                            blk_cnt_d   = (blk_cnt_q == 16'd0) ? 16'd0 : blk_cnt_q - 16'd1;
                        end else begin
                            unf_set = 1'b1;
                        end
                    end else begin
                        issue = 1'b1;
                    end

                    if (issue) begin
                        if (stripe_q == LAST_STRIPE) begin
                            // Wrap straight to stripe 0 so the next block can
                            // start in the following cycle.
                            stripe_d = 2'd0;
                            if (blk_cnt_d == 16'd0) begin
                                state_d = ST_DONE;
                            end
                        end else begin
                            stripe_d = stripe_q + 2'd1;
                        end
                    end
                end
            end

            ST_DONE: begin
                eol_d   = 1'b1;
                clr_d   = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Losing the enable drops the line: no read, no end-of-line, and the
        // FIFO is cleared so partially read blocks are discarded.
        if (abort) begin
            state_d     = ST_IDLE;
            stripe_d    = 2'd0;
            issue       = 1'b0;
            issue_start = 1'b0;
            unf_set     = 1'b0;
            eol_d       = 1'b0;
            clr_d       = 1'b1;
        end

        if ((state_q == ST_IDLE) && (state_d == ST_PREFILL)) begin
            pend_hist_d = 2'b00;
        end else begin
            pend_hist_d = {pend_hist_q[0], issue_start};
        end

        stripe_oh = issue ? (P_STRIPES'(1) << stripe_q) : '0;
        rd_d      = {(P_LANES * P_SEGMENTS){stripe_oh}};

        if (unf_set) begin
            unf_d = 1'b1;
        end else if (STA_UNF_CLR_IN) begin
            unf_d = 1'b0;
        end else begin
            unf_d = unf_q;
        end
    end

    always_ff @(posedge VID_CLK_IN or negedge VID_RST_N_IN) begin
        if (!VID_RST_N_IN) begin
            state_q     <= ST_IDLE;
            stripe_q    <= 2'd0;
            blk_cnt_q   <= 16'd0;
            thr_q       <= '0;
            pend_hist_q <= 2'b00;
            rd_q        <= '0;
            clr_q       <= 1'b0;
            eol_q       <= 1'b0;
            busy_q      <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            stripe_q    <= stripe_d;
            blk_cnt_q   <= blk_cnt_d;
            thr_q       <= thr_d;
            pend_hist_q <= pend_hist_d;
            rd_q        <= rd_d;
            clr_q       <= clr_d;
            eol_q       <= eol_d;
            busy_q      <= busy_d;
            unf_q       <= unf_d;
        end
    end

    assign vid_if.FIFO_RD_OUT  = rd_q;
    assign vid_if.FIFO_CLR_OUT = clr_q;
    assign vid_if.VID_EOL_OUT  = eol_q;
    assign STA_BUSY_OUT        = busy_q;
    assign STA_UNF_OUT         = unf_q;

endmodule

// File: tb/tb_prt_dprx_vid_fifo_rdctl.sv
// tb/tb_prt_dprx_vid_fifo_rdctl.sv - directed bench for the video FIFO read controller
module tb_prt_dprx_vid_fifo_rdctl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ctl_en;
    logic        unf_clr;
    logic [15:0] cfg_blk;
    logic [5:0]  cfg_thr;
    logic        busy_a, unf_a, busy_b, unf_b;

    int n_vec = 0;
    int n_bad = 0;

    // Downstream ready applied before rising edge k of the backpressure line
    int bp_req[11] = '{0, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1};
    // Stripe expected on the outputs after edge k (-1: no read)
    int bp_exp[11] = '{-1, -1, -1, 0, 1, -1, -1, 2, 3, -1, -1};

    prt_dprx_vid_fifo_rdctl_if #(.P_LANES(4), .P_SEGMENTS(4), .P_STRIPES(4), .P_LVL_W(6)) if_a ();
    prt_dprx_vid_fifo_rdctl_if #(.P_LANES(4), .P_SEGMENTS(4), .P_STRIPES(1), .P_LVL_W(6)) if_b ();

    prt_dprx_vid_fifo_rdctl #(.P_LANES(4), .P_SEGMENTS(4), .P_STRIPES(4), .P_LVL_W(6)) u_dut_a (
        .VID_CLK_IN     (clk),
        .VID_RST_N_IN   (rst_n),
        .CTL_EN_IN      (ctl_en),
        .CFG_BLK_IN     (cfg_blk),
        .CFG_THR_IN     (cfg_thr),
        .STA_BUSY_OUT   (busy_a),
        .STA_UNF_OUT    (unf_a),
        .STA_UNF_CLR_IN (unf_clr),
        .vid_if         (if_a.master)
    );

    prt_dprx_vid_fifo_rdctl #(.P_LANES(4), .P_SEGMENTS(4), .P_STRIPES(1), .P_LVL_W(6)) u_dut_b (
        .VID_CLK_IN     (clk),
        .VID_RST_N_IN   (rst_n),
        .CTL_EN_IN      (ctl_en),
        .CFG_BLK_IN     (cfg_blk),
        .CFG_THR_IN     (cfg_thr),
        .STA_BUSY_OUT   (busy_b),
        .STA_UNF_OUT    (unf_b),
        .STA_UNF_CLR_IN (unf_clr),
        .vid_if         (if_b.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Stripe index of a legal stripe cycle, -1 for no read, -2 for anything else
    function automatic int dec_a(input logic [3:0][3:0][3:0] v);
        logic [3:0][3:0][3:0] p;
        if (v == '0) return -1;
        for (int s = 0; s < 4; s++) begin
            p = '0;
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    p[i][j][s] = 1'b1;
            if (v == p) return s;
        end
        return -2;
    endfunction

    function automatic int dec_b(input logic [15:0] v);
        if (v == 16'h0000) return -1;
        if (v == 16'hffff) return 0;
        return -2;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_idle_a(input string tag);
        int k;
        k = 0;
        while (busy_a === 1'b1 && k < 60) begin
            tick();
            k++;
        end
        chk(tag, busy_a, 0);
    endtask

    initial begin
        int exp_rd;
        int found;
        int early;
        int reads;
        int illegal;
        int d1, d2;

        ctl_en  = 1'b1;
        unf_clr = 1'b0;
        cfg_blk = 16'd3;
        cfg_thr = 6'd2;
        if_a.VID_SOL_IN  = 1'b0;
        if_a.VID_REQ_IN  = 1'b1;
        if_a.FIFO_LVL_IN = 6'd8;
        if_b.VID_SOL_IN  = 1'b0;
        if_b.VID_REQ_IN  = 1'b0;
        if_b.FIFO_LVL_IN = 6'd0;

        // Reset state
        repeat (3) tick();
        chk("rst_rd_a",   dec_a(if_a.FIFO_RD_OUT), -1);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_unf_a",  unf_a, 0);
        chk("rst_eol_a",  if_a.VID_EOL_OUT, 0);
        chk("rst_clr_a",  if_a.FIFO_CLR_OUT, 0);
        chk("rst_rd_b",   dec_b(if_b.FIFO_RD_OUT), -1);
        rst_n = 1'b1;
        repeat (2) tick();

        // Nominal: 3 blocks x 4 stripes, then one end-of-line/clear cycle
        if_a.VID_SOL_IN = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if_a.VID_SOL_IN = 1'b0;
            exp_rd = (k >= 3 && k <= 14) ? (k - 3) % 4 : -1;
            chk($sformatf("nom_rd_%0d", k),   dec_a(if_a.FIFO_RD_OUT), exp_rd);
            chk($sformatf("nom_eol_%0d", k),  if_a.VID_EOL_OUT, (k == 15) ? 1 : 0);
            chk($sformatf("nom_clr_%0d", k),  if_a.FIFO_CLR_OUT, (k == 15) ? 1 : 0);
            chk($sformatf("nom_busy_%0d", k), busy_a, (k >= 2 && k <= 15) ? 1 : 0);
        end
        chk("nom_unf", unf_a, 0);

        // Prefill: threshold 4 sampled at line start; changing it afterwards has no effect
        cfg_blk = 16'd1;
        cfg_thr = 6'd4;
        if_a.FIFO_LVL_IN = 6'd0;
        if_a.VID_SOL_IN = 1'b1;
        tick();
        if_a.VID_SOL_IN = 1'b0;
        cfg_thr = 6'd0;
        early = 0;
        for (int step = 0; step < 4; step++) begin
            if_a.FIFO_LVL_IN = 6'(step);
            for (int c = 0; c < 10; c++) begin
                tick();
                if (dec_a(if_a.FIFO_RD_OUT) != -1) early++;
            end
        end
        chk("pre_noread", early, 0);
        if_a.FIFO_LVL_IN = 6'd4;
        found = -1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (found < 0 && dec_a(if_a.FIFO_RD_OUT) == 0) found = k;
        end
        chk("pre_latency", found, 2);
        wait_idle_a("pre_idle");
        tick();

        // Backpressure: ready 1,0,0,1 mid-block pauses and resumes at the next stripe
        cfg_blk = 16'd1;
        cfg_thr = 6'd0;
        if_a.FIFO_LVL_IN = 6'd8;
        if_a.VID_SOL_IN = 1'b1;
        if_a.VID_REQ_IN = bp_req[1] != 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if_a.VID_SOL_IN = 1'b0;
            chk($sformatf("bp_rd_%0d", k),  dec_a(if_a.FIFO_RD_OUT), bp_exp[k]);
            chk($sformatf("bp_eol_%0d", k), if_a.VID_EOL_OUT, (k == 9) ? 1 : 0);
            if (k < 10) if_a.VID_REQ_IN = bp_req[k + 1] != 0;
        end
        chk("bp_unf", unf_a, 0);
        if_a.VID_REQ_IN = 1'b1;
        tick();

        // Abort at block 2 stripe 1
        cfg_blk = 16'd3;
        cfg_thr = 6'd0;
        if_a.VID_SOL_IN = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if_a.VID_SOL_IN = 1'b0;
            exp_rd = (k >= 3 && k <= 7) ? (k - 3) % 4 : -1;
            chk($sformatf("ab_rd_%0d", k),   dec_a(if_a.FIFO_RD_OUT), exp_rd);
            chk($sformatf("ab_clr_%0d", k),  if_a.FIFO_CLR_OUT, (k == 8) ? 1 : 0);
            chk($sformatf("ab_eol_%0d", k),  if_a.VID_EOL_OUT, 0);
            chk($sformatf("ab_busy_%0d", k), busy_a, (k >= 2 && k <= 8) ? 1 : 0);
            if (k == 7) ctl_en = 1'b0;
        end
        ctl_en = 1'b1;
        tick();

        // SOL while in DONE is ignored
        cfg_blk = 16'd1;
        if_a.VID_SOL_IN = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if_a.VID_SOL_IN = 1'b0;
            exp_rd = (k >= 3 && k <= 6) ? (k - 3) : -1;
            chk($sformatf("dn_rd_%0d", k),   dec_a(if_a.FIFO_RD_OUT), exp_rd);
            chk($sformatf("dn_busy_%0d", k), busy_a, (k >= 2 && k <= 7) ? 1 : 0);
            if (k == 6) if_a.VID_SOL_IN = 1'b1;
        end

        // Underflow with one stripe per block, one block preloaded, level lags starts by two cycles
        cfg_blk = 16'd5;
        cfg_thr = 6'd1;
        if_b.FIFO_LVL_IN = 6'd1;
        if_b.VID_REQ_IN = 1'b1;
        if_b.VID_SOL_IN = 1'b1;
        reads = 0;
        illegal = 0;
        d1 = 0;
        d2 = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if_b.VID_SOL_IN = 1'b0;
            if (dec_b(if_b.FIFO_RD_OUT) == 0) reads++;
            if (dec_b(if_b.FIFO_RD_OUT) == -2) illegal++;
            if (k == 3) chk("unf_before", unf_b, 0);
            if (k == 4) chk("unf_set", unf_b, 1);
            if (d2 != 0 && if_b.FIFO_LVL_IN != 6'd0) if_b.FIFO_LVL_IN = if_b.FIFO_LVL_IN - 6'd1;
            d2 = d1;
            d1 = (dec_b(if_b.FIFO_RD_OUT) == 0) ? 1 : 0;
        end
        chk("unf_reads", reads, 1);
        chk("unf_illegal", illegal, 0);
        chk("unf_sticky", unf_b, 1);
        chk("unf_busy", busy_b, 1);
        chk("unf_other", unf_a, 0);

        // Set and clear together: set wins; clear alone then drops the flag
        unf_clr = 1'b1;
        tick();
        tick();
        chk("unf_set_wins", unf_b, 1);
        if_b.VID_REQ_IN = 1'b0;
        tick();
        chk("unf_cleared", unf_b, 0);
        unf_clr = 1'b0;

        // Abort the stalled line
        ctl_en = 1'b0;
        tick();
        chk("unf_ab_clr", if_b.FIFO_CLR_OUT, 1);
        chk("unf_ab_eol", if_b.VID_EOL_OUT, 0);
        tick();
        chk("unf_ab_busy", busy_b, 0);
        ctl_en = 1'b1;
        tick();

        // Reset mid-RUN
        cfg_blk = 16'd3;
        cfg_thr = 6'd0;
        if_a.FIFO_LVL_IN = 6'd8;
        if_a.VID_REQ_IN = 1'b1;
        if_a.VID_SOL_IN = 1'b1;
        tick();
        if_a.VID_SOL_IN = 1'b0;
        repeat (4) tick();
        chk("rs_pre_rd", dec_a(if_a.FIFO_RD_OUT), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_rd",   dec_a(if_a.FIFO_RD_OUT), -1);
        chk("rs_busy", busy_a, 0);
        chk("rs_eol",  if_a.VID_EOL_OUT, 0);
        chk("rs_clr",  if_a.FIFO_CLR_OUT, 0);
        chk("rs_unf",  unf_a, 0);
        tick();
        rst_n = 1'b1;
        early = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (dec_a(if_a.FIFO_RD_OUT) != -1) early++;
            if (busy_a !== 1'b0) early++;
            if (if_a.FIFO_CLR_OUT !== 1'b0) early++;
        end
        chk("rs_quiet", early, 0);
        if_a.VID_SOL_IN = 1'b1;
        tick();
        if_a.VID_SOL_IN = 1'b0;
        tick();
        tick();
        chk("rs_restart_rd", dec_a(if_a.FIFO_RD_OUT), 0);
        wait_idle_a("rs_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
